// File: rtl/pool_relu_serializer.sv
// pool_relu_serializer: latches a full conv-layer output vector, applies
// optional ReLU, and streams non-overlapping max-pooled words one per
// valid/ready handshake. Holds a single vector until it has fully drained.
module pool_relu_serializer #(
    parameter int INPUT_LENGTH = 2,
    parameter int POOL_SIZE    = 1,
    parameter int WORD_SIZE    = 16,
    parameter int RELU_EN      = 1
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  valid_i,
    output logic                                  yumi_o,
    input  logic [INPUT_LENGTH-1:0][WORD_SIZE-1:0] data_i,
    output logic                                  valid_o,
    input  logic                                  ready_i,
    output logic [WORD_SIZE-1:0]                  data_o,
    output logic                                  last_o
);

    localparam int NUM_OUT = INPUT_LENGTH / POOL_SIZE;
    localparam int IDX_W   = $clog2(NUM_OUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);

    if (INPUT_LENGTH < 1 || POOL_SIZE < 1 || (INPUT_LENGTH % POOL_SIZE) != 0) begin : g_bad_params
        $error("pool_relu_serializer: INPUT_LENGTH must be >= 1 and a multiple of POOL_SIZE");
    end

    typedef enum logic {
        eEMPTY,
        eSEND
    } state_e;

    state_e                                ps;
    logic [IDX_W-1:0]                      out_idx;
    logic [INPUT_LENGTH-1:0][WORD_SIZE-1:0] vec_q;
    logic [WORD_SIZE-1:0]                  pool_max;
    logic                                  found;

    function automatic logic [WORD_SIZE-1:0] relu(input logic [WORD_SIZE-1:0] w);
        logic [WORD_SIZE-1:0] r;
        r = w;
        if (RELU_EN != 0 && w[WORD_SIZE-1]) begin
            r = '0;
        end
        return r;
    endfunction

    assign yumi_o  = (ps == eEMPTY) && valid_i && !reset_i;
    assign valid_o = (ps == eSEND);
    assign last_o  = valid_o && (out_idx == LAST_IDX);
    assign data_o  = valid_o ? pool_max : '0;

    // Control FSM: accept a vector when empty, then step through pool windows.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ps      <= eEMPTY;
            out_idx <= '0;
        end else begin
            case (ps)
                eEMPTY: begin
                    if (yumi_o) begin
                        ps      <= eSEND;
                        out_idx <= '0;
                    end
                end
                eSEND: begin
                    if (ready_i) begin
                        if (out_idx == LAST_IDX) begin
                            ps      <= eEMPTY;
                            out_idx <= '0;
                        end else begin
                            out_idx <= out_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    ps      <= eEMPTY;
                    out_idx <= '0;
                end
            endcase
        end
    end

    // Vector storage: loaded only on a consumed vector; never reset since data_o is masked.
    always_ff @(posedge clk_i) begin
        if (yumi_o) begin
            for (int unsigned k = 0; k < INPUT_LENGTH; k++) begin
                vec_q[k] <= relu(data_i[k]);
            end
        end
    end

    // Signed max over the current window; strict compare keeps the lowest index on ties.
    always_comb begin
        pool_max = '0;
        found    = 1'b0;
        for (int unsigned k = 0; k < INPUT_LENGTH; k++) begin
            if ((k / POOL_SIZE) == 32'(out_idx)) begin
                if (!found || ($signed(vec_q[k]) > $signed(pool_max))) begin
                    pool_max = vec_q[k];
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pool_relu_serializer.sv
// Self-checking bench for pool_relu_serializer: three configurations driven
// side by side, a cycle-level reference model checking every output each
// cycle, plus directed checks of the accepted word streams.
module tb_pool_relu_serializer;

    logic               clk = 1'b0;
    logic               rst;
    logic               vld_i [3];
    logic               rdy_i [3];
    logic               yumi  [3];
    logic               vo    [3];
    logic               lo    [3];
    logic [15:0]        dout  [3];
    logic [3:0][15:0]   din   [3];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model state
    bit          busy  [3];
    int          pos   [3];
    int          exp_n [3];
    logic [15:0] exp_w [3][4];

    // logs of what the DUTs delivered
    logic [15:0] got_w      [3][$];
    bit          got_l      [3][$];
    int          yumi_cyc   [3][$];
    int          lastacc_cyc[3][$];

    always #5 clk = ~clk;

    pool_relu_serializer #(.INPUT_LENGTH(4), .POOL_SIZE(2), .WORD_SIZE(16), .RELU_EN(1)) u_a (
        .clk_i(clk), .reset_i(rst), .valid_i(vld_i[0]), .yumi_o(yumi[0]), .data_i(din[0]),
        .valid_o(vo[0]), .ready_i(rdy_i[0]), .data_o(dout[0]), .last_o(lo[0]));

    pool_relu_serializer #(.INPUT_LENGTH(4), .POOL_SIZE(2), .WORD_SIZE(16), .RELU_EN(0)) u_b (
        .clk_i(clk), .reset_i(rst), .valid_i(vld_i[1]), .yumi_o(yumi[1]), .data_i(din[1]),
        .valid_o(vo[1]), .ready_i(rdy_i[1]), .data_o(dout[1]), .last_o(lo[1]));

    pool_relu_serializer #(.INPUT_LENGTH(3), .POOL_SIZE(3), .WORD_SIZE(16), .RELU_EN(0)) u_c (
        .clk_i(clk), .reset_i(rst), .valid_i(vld_i[2]), .yumi_o(yumi[2]), .data_i(din[2][2:0]),
        .valid_o(vo[2]), .ready_i(rdy_i[2]), .data_o(dout[2]), .last_o(lo[2]));

    function automatic int len_of(input int i);
        return (i == 2) ? 3 : 4;
    endfunction

    function automatic int pool_of(input int i);
        return (i == 2) ? 3 : 2;
    endfunction

    function automatic bit relu_of(input int i);
        return (i == 0);
    endfunction

    function automatic logic [15:0] relu_m(input int i, input logic [15:0] w);
        return (relu_of(i) && w[15]) ? 16'h0000 : w;
    endfunction

    // pooled output j of a vector for configuration i
    function automatic logic [15:0] model_word(input int i, input logic [3:0][15:0] w, input int j);
        int p;
        logic [15:0] m, v;
        p = pool_of(i);
        m = relu_m(i, w[j*p]);
        for (int q = 1; q < p; q++) begin
            v = relu_m(i, w[j*p+q]);
            if ($signed(v) > $signed(m)) m = v;
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Per-cycle model comparison, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            logic ey;
            ey = vld_i[i] && !rst && !busy[i];
            check($sformatf("i%0d yumi", i), 32'(yumi[i]), 32'(ey));
            check($sformatf("i%0d valid", i), 32'(vo[i]), 32'(busy[i]));
            if (busy[i]) begin
                check($sformatf("i%0d data", i), 32'(dout[i]), 32'(exp_w[i][pos[i]]));
                check($sformatf("i%0d last", i), 32'(lo[i]), 32'(pos[i] == exp_n[i] - 1));
            end else begin
                check($sformatf("i%0d idle data", i), 32'(dout[i]), 32'h0);
                check($sformatf("i%0d idle last", i), 32'(lo[i]), 32'h0);
            end
            if (yumi[i]) yumi_cyc[i].push_back(cyc);
            if (vo[i] && rdy_i[i]) begin
                got_w[i].push_back(dout[i]);
                got_l[i].push_back(lo[i]);
                if (lo[i]) lastacc_cyc[i].push_back(cyc);
            end
            // advance the model to the state after the coming edge
            if (rst) begin
                busy[i] = 1'b0;
            end else if (ey) begin
                exp_n[i] = len_of(i) / pool_of(i);
                for (int j = 0; j < exp_n[i]; j++) exp_w[i][j] = model_word(i, din[i], j);
                pos[i]  = 0;
                busy[i] = 1'b1;
            end else if (busy[i] && rdy_i[i]) begin
                pos[i]++;
                if (pos[i] == exp_n[i]) busy[i] = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 3; i++) begin
            got_w[i].delete();
            got_l[i].delete();
            yumi_cyc[i].delete();
            lastacc_cyc[i].delete();
        end
    endtask

    task automatic check_word(input string tag, input int i, input int k,
                              input logic [15:0] ew, input bit el);
        check({tag, " word"}, (got_w[i].size() > k) ? 32'(got_w[i][k]) : 32'hFFFF_FFFF, 32'(ew));
        check({tag, " last"}, (got_l[i].size() > k) ? 32'(got_l[i][k]) : 32'hFFFF_FFFF, 32'(el));
    endtask

    task automatic send(input int i, input logic [3:0][15:0] v);
        din[i]   = v;
        vld_i[i] = 1'b1;
        tick(1);
        vld_i[i] = 1'b0;
    endtask

    logic [3:0][15:0] v1, v2, v3, v6;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vld_i[i] = 1'b0;
            rdy_i[i] = 1'b1;
            din[i]   = '0;
            busy[i]  = 1'b0;
            pos[i]   = 0;
            exp_n[i] = 1;
        end
        v1 = {16'hFE00, 16'hFF00, 16'h0300, 16'h0100};
        v2 = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
        v3 = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        v6 = {16'h0000, 16'h0000, 16'h7FFF, 16'h8000};
        tick(2);
        check("reset valid", 32'(vo[0]), 32'h0);
        check("reset data", 32'(dout[0]), 32'h0);
        rst = 1'b0;
        tick(1);
        clear_logs();

        // 1 and 2: ReLU on / off with the same vector
        din[0] = v1; din[1] = v1;
        vld_i[0] = 1'b1; vld_i[1] = 1'b1;
        tick(1);
        vld_i[0] = 1'b0; vld_i[1] = 1'b0;
        tick(3);
        check("t1 yumi count", yumi_cyc[0].size(), 1);
        check("t1 count", got_w[0].size(), 2);
        check_word("t1 w0", 0, 0, 16'h0300, 1'b0);
        check_word("t1 w1", 0, 1, 16'h0000, 1'b1);
        check("t2 count", got_w[1].size(), 2);
        check_word("t2 w0", 1, 0, 16'h0300, 1'b0);
        check_word("t2 w1", 1, 1, 16'hFF00, 1'b1);
        clear_logs();

        // 3: backpressure holds the first word
        rdy_i[0] = 1'b0;
        send(0, v1);
        tick(3);
        check("t3 held data", 32'(dout[0]), 32'h0300);
        check("t3 none taken", got_w[0].size(), 0);
        rdy_i[0] = 1'b1;
        tick(3);
        check("t3 count", got_w[0].size(), 2);
        check_word("t3 w0", 0, 0, 16'h0300, 1'b0);
        check_word("t3 w1", 0, 1, 16'h0000, 1'b1);
        clear_logs();

        // 4: valid held high across two vectors
        din[0] = v1;
        vld_i[0] = 1'b1;
        tick(1);
        din[0] = v2;
        tick(4);
        vld_i[0] = 1'b0;
        tick(3);
        check("t4 yumi count", yumi_cyc[0].size(), 2);
        check("t4 gap", (yumi_cyc[0].size() > 1 && lastacc_cyc[0].size() > 0) ?
              32'(yumi_cyc[0][1] - lastacc_cyc[0][0]) : 32'hFFFF_FFFF, 32'd1);
        check("t4 count", got_w[0].size(), 4);
        check_word("t4 w2", 0, 2, 16'h0020, 1'b0);
        check_word("t4 w3", 0, 3, 16'h0040, 1'b1);
        clear_logs();

        // 5: reset while the first word is pending
        rdy_i[0] = 1'b0;
        send(0, v1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t5 valid after reset", 32'(vo[0]), 32'h0);
        check("t5 data after reset", 32'(dout[0]), 32'h0);
        rdy_i[0] = 1'b1;
        send(0, v3);
        tick(3);
        check("t5 count", got_w[0].size(), 2);
        check_word("t5 w0", 0, 0, 16'h0002, 1'b0);
        check_word("t5 w1", 0, 1, 16'h0004, 1'b1);
        clear_logs();

        // 6: single window covering the whole vector
        send(2, v6);
        tick(2);
        check("t6 count", got_w[2].size(), 1);
        check_word("t6 w0", 2, 0, 16'h7FFF, 1'b1);
        clear_logs();

        // random traffic on all three, checked by the per-cycle model
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            for (int i = 0; i < 3; i++) begin
                vld_i[i] = ($urandom_range(0, 2) != 0);
                rdy_i[i] = ($urandom_range(0, 3) != 0);
                for (int k = 0; k < 4; k++) din[i][k] = 16'($urandom);
            end
            tick(1);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vld_i[i] = 1'b0;
            rdy_i[i] = 1'b1;
        end
        tick(8);
        for (int i = 0; i < 3; i++) check($sformatf("i%0d drained", i), 32'(vo[i]), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pool_relu_serializer.md
Name: pool_relu_serializer

Overview:
- Downstream neighbour of the convolutional layer. Accepts that layer's full parallel output vector through a valid/yumi handshake.
- Applies optional ReLU, then non-overlapping max-pooling, then streams the pooled words one per handshake over valid/ready. The stream feeds the serial-input dense layer.
- Holds one vector at a time. Does not accept a new vector until the current one is fully drained.

Parameters:
- INPUT_LENGTH, 2, number of words in data_i (conv output count); must be >= 1.
- POOL_SIZE, 1, max-pool window width; INPUT_LENGTH % POOL_SIZE must be 0 (elaboration-time assertion).
- WORD_SIZE, 16, bits per signed fixed-point word.
- RELU_EN, 1, 1 = clamp negative words to 0 before pooling; 0 = bypass.

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- reset_i  input  1  synchronous, active-high reset.
- valid_i  input  1  upstream vector valid.
- yumi_o  output  1  upstream vector consumed this cycle.
- data_i  input  [INPUT_LENGTH-1:0][WORD_SIZE-1:0]  signed upstream words; index 0 is the first element.
- valid_o  output  1  data_o holds a valid pooled word.
- ready_i  input  1  downstream ready.
- data_o  output  WORD_SIZE  signed pooled word; 0 when valid_o = 0.
- last_o  output  1  high with the final pooled word of a vector (qualified by valid_o).

Behaviour:
- Derived: NUM_OUT = INPUT_LENGTH/POOL_SIZE. out_idx counter is $clog2(NUM_OUT+1) bits wide.
- States: eEMPTY, eSEND.
- eEMPTY:
  - yumi_o = valid_i && !reset_i (combinational, same cycle as valid_i).
  - On yumi_o: register every word as relu(data_i[k]) (or the raw word if RELU_EN=0); out_idx <= 0; ns = eSEND.
- eSEND:
  - valid_o = 1; yumi_o = 0.
  - data_o = signed max of stored words [out_idx*POOL_SIZE .. out_idx*POOL_SIZE+POOL_SIZE-1], computed combinationally from the registers.
  - On valid_o && ready_i: if out_idx == NUM_OUT-1 then ns = eEMPTY and out_idx <= 0; else out_idx <= out_idx+1.
  - data_o is stable while ready_i is low.
- last_o = (ps == eSEND) && (out_idx == NUM_OUT-1).
- ReLU: a word whose MSB is 1 becomes 0; otherwise the word passes unchanged. No width growth, no saturation.
- Max comparison is signed two's complement. On a tie, the lower index wins (the value is identical either way).
- Latency: vector handshake at cycle t; first valid_o at t+1; with ready_i held high, the last word is accepted at t+NUM_OUT. The earliest next yumi_o is t+NUM_OUT+1 (no same-cycle drain/refill).
- NUM_OUT = 1: a single word with last_o = 1, then return to eEMPTY.
- POOL_SIZE = 1: pure ReLU + serializer.
- Stored vector registers update only on yumi_o. They keep their value otherwise and are not cleared by reset, because data_o is masked whenever valid_o = 0.
- Reset (any state, including mid-drain): next cycle ps = eEMPTY, out_idx = 0, valid_o = 0, last_o = 0, data_o = 0. The partial vector is discarded. yumi_o = 0 during the reset cycle even if valid_i = 1.
- Reset values: valid_o 0, last_o 0, data_o 0, yumi_o 0.

Test Plan:
1. Basic pooling with ReLU. INPUT_LENGTH=4, POOL_SIZE=2, RELU_EN=1, data_i = {[0]=0x0100,[1]=0x0300,[2]=0xFF00,[3]=0xFE00}, ready_i=1.
   - Required: yumi_o pulses 1 cycle.
   - Next cycle: data_o=0x0300, last_o=0.
   - Following cycle: data_o=0x0000, last_o=1.
   - Then valid_o=0.
2. Same stimulus with RELU_EN=0.
   - Required: outputs 0x0300 then 0xFF00 (signed max of 0xFF00 and 0xFE00).
3. Backpressure. Scenario 1 with ready_i=0 for 3 cycles after valid_o rises.
   - Required: data_o holds 0x0300 and out_idx does not advance.
   - Release ready_i: 0x0300 then 0x0000 are delivered, in order, exactly once each.
4. Input blocking. valid_i held high continuously with a second vector {0x0010,0x0020,0x0030,0x0040}.
   - Required: yumi_o stays 0 throughout eSEND.
   - Second yumi_o occurs exactly 1 cycle after the first vector's last word is accepted.
   - Second vector's outputs: 0x0020, 0x0040.
5. Reset mid-drain. Assert reset_i for 1 cycle while the first of 2 words is pending.
   - Required: valid_o=0 the following cycle.
   - The next vector {0x0001,0x0002,0x0003,0x0004} yields 0x0002, 0x0004; no stale word appears.
6. Degenerate pooling. INPUT_LENGTH=3, POOL_SIZE=3, data_i={0x8000,0x7FFF,0x0000}, RELU_EN=0.
   - Required: one word 0x7FFF with last_o=1.
